haar_lift_engine: RTL

Parametrised, pipelined integer Haar lifting engine that replaces the fixed-function 16-bit reprocess stage. It runs the forward transform (even/odd samples to detail/approx) or the inverse transform (detail/approx to even/odd), selected per frame. Outputs saturate to the sample width, with a per-sample saturation flag and an end-of-frame marker. It sits between the image sample memories and the coordinate/coefficient writers, one sample pair per clock.

---
 rtl/haar_lift_engine_if.sv | 34 +++
 rtl/haar_lift_engine.sv | 128 ++++++++++++
 2 files changed

// File: rtl/haar_lift_engine_if.sv
// -----------------------------------------------------------------------------
// haar_lift_engine_if
// Sample-pair bus between a source (master) and the Haar lifting engine (slave).
//   start      : input-valid, one pair per clock
//   mode       : 0 = forward, 1 = inverse (only honoured on a frame's first pair)
//   im11/im21  : input pair (forward: e/o, inverse: d/s)
//   x1/y1      : output pair (forward: d/s, inverse: e/o)
//   data_occur : x1/y1 valid
//   frame_done : last pair of a frame
//   sat_flag   : x1 or y1 was clamped
// -----------------------------------------------------------------------------
interface haar_lift_engine_if #(
  parameter int DW = 16
);
  logic                 start;
  logic                 mode;
  logic signed [DW-1:0] im11;
  logic signed [DW-1:0] im21;
  logic signed [DW-1:0] x1;
  logic signed [DW-1:0] y1;
  logic                 data_occur;
  logic                 frame_done;
  logic                 sat_flag;

  modport master (
    output start, mode, im11, im21,
    input  x1, y1, data_occur, frame_done, sat_flag
  );

  modport slave (
    input  start, mode, im11, im21,
    output x1, y1, data_occur, frame_done, sat_flag
  );
endinterface

// File: rtl/haar_lift_engine.sv
// -----------------------------------------------------------------------------
// haar_lift_engine
// Two-stage pipelined integer Haar lifting engine, one sample pair per clock.
//   Forward: d = o - e;          s = e + (d >>> 1)
//   Inverse: e = s - (d >>> 1);  o = d + e
// Internal arithmetic is DW+2 bits signed; results clamp to DW bits at the
// output only. Mode is sampled on the first pair of each FRAME_LEN-pair frame.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : haar_lift_engine_if.slave (inputs start/mode/im11/im21,
//           outputs x1/y1/data_occur/frame_done/sat_flag)
// -----------------------------------------------------------------------------
module haar_lift_engine #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 4096
) (
  input  logic               clk,
  input  logic               reset,
  haar_lift_engine_if.slave  bus
);

  localparam int IW = DW + 2;
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
  localparam logic signed [IW-1:0] MAX_V = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_V = {3'b111, {(DW-1){1'b0}}};

  typedef enum logic {ST_FWD = 1'b0, ST_INV = 1'b1} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;

  // Stage 1: first-equation result plus the im11 operand (e in forward,
  // d in inverse), which is exactly what the second equation needs.
  logic                  r_s1_valid;
  logic                  r_s1_last;
  logic                  r_s1_inv;
  logic signed [IW-1:0]  r_s1_a;
  logic signed [IW-1:0]  r_s1_b;

  // Stage 2: registered outputs.
  logic signed [DW-1:0]  r_x1;
  logic signed [DW-1:0]  r_y1;
  logic                  r_data_occur;
  logic                  r_frame_done;
  logic                  r_sat_flag;

  logic                  w_first;
  logic                  w_last;
  logic                  w_inv;
  logic signed [IW-1:0]  w_im11;
  logic signed [IW-1:0]  w_im21;
  logic signed [IW-1:0]  w_first_res;
  logic signed [IW-1:0]  w_second_res;
  logic                  w_x_sat;
  logic                  w_y_sat;

  function automatic logic signed [DW-1:0] clamp(input logic signed [IW-1:0] v);
    if (v > MAX_V)      return MAX_V[DW-1:0];
    else if (v < MIN_V) return MIN_V[DW-1:0];
    else                return v[DW-1:0];
  endfunction

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LAST_CNT);
  // The first pair of a frame already runs in the mode presented with it.
  assign w_inv   = w_first ? bus.mode : (r_state == ST_INV);
  assign w_im11  = {{2{bus.im11[DW-1]}}, bus.im11};
  assign w_im21  = {{2{bus.im21[DW-1]}}, bus.im21};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_first_res  = w_im21 - w_im11;
    w_second_res = r_s1_b + (r_s1_a >>> 1);
    if (w_inv)    w_first_res  = w_im21 - (w_im11 >>> 1);
    if (r_s1_inv) w_second_res = r_s1_b + r_s1_a;
  end

  assign w_x_sat = (r_s1_a > MAX_V) || (r_s1_a < MIN_V);
  assign w_y_sat = (w_second_res > MAX_V) || (w_second_res < MIN_V);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_FWD;
      r_cnt        <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_inv     <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_data_occur <= 1'b0;
      r_frame_done <= 1'b0;
      r_sat_flag   <= 1'b0;
    end else begin
      r_s1_valid <= bus.start;
      if (bus.start) begin
        r_cnt     <= w_last ? '0 : r_cnt + CW'(1);
        if (w_first) r_state <= bus.mode ? ST_INV : ST_FWD;
        r_s1_last <= w_last;
        r_s1_inv  <= w_inv;
        r_s1_a    <= w_first_res;
        r_s1_b    <= w_im11;
      end

      // Bubbles leave x1/y1 holding the last valid pair.
      r_data_occur <= r_s1_valid;
      r_frame_done <= r_s1_valid & r_s1_last;
      r_sat_flag   <= r_s1_valid & (w_x_sat | w_y_sat);
      if (r_s1_valid) begin
        r_x1 <= clamp(r_s1_a);
        r_y1 <= clamp(w_second_res);
      end
    end
  end

  assign bus.x1         = r_x1;
  assign bus.y1         = r_y1;
  assign bus.data_occur = r_data_occur;
  assign bus.frame_done = r_frame_done;
  assign bus.sat_flag   = r_sat_flag;

endmodule
